// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
//   Shared types and helpers for the bit-serial adder.
//   - sa_state_t    : control FSM states (IDLE, ADD, DONE)
//   - DEFAULT_WIDTH : default operand width
//   - cnt_width()   : bit counter width, $clog2(WIDTH) but never below 1
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } sa_state_t;

  localparam int DEFAULT_WIDTH = 8;

  // WIDTH=1 would give $clog2(1)=0, which is not a legal vector width.
  function automatic int cnt_width(input int width);
    int w;
    w = $clog2(width);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/serial_adder_full_adder_bit.sv
// full_adder_bit
//   One-bit full adder built from two half-adder stages and an OR.
//   Ports:
//     x, y  : input  addend bits
//     cin   : input  carry in
//     s     : output sum bit
//     co    : output carry out
module full_adder_bit (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic co
);

  logic p1;
  logic g1;
  logic g2;

  // First half adder: x + y
  assign p1 = x ^ y;
  assign g1 = x & y;

  // Second half adder: partial sum + cin
  assign s  = p1 ^ cin;
  assign g2 = p1 & cin;

  assign co = g1 | g2;

endmodule

// File: rtl/serial_adder.sv
// serial_adder
//   Bit-serial adder: operands are added LSB-first through a single
//   full_adder_bit and a carry register, one bit per clock.
//   Request side is valid/ready (this block responds), result side is
//   valid/ready towards the downstream consumer.
//
//   Optional build macro SERIAL_ADDER_SUB_EN adds input 'sub': when set
//   with a request, the block computes (a-b) mod 2^WIDTH and cout=1 means
//   no borrow.
//
//   Ports:
//     clk       : input  clock, rising edge
//     rst_n     : input  asynchronous active-low reset
//     in_valid  : input  request valid
//     in_ready  : output block can accept a request (high only in IDLE)
//     sub       : input  subtract select (SERIAL_ADDER_SUB_EN only)
//     a, b      : input  [WIDTH-1:0] operands, sampled on handshake
//     out_valid : output result valid
//     out_ready : input  downstream takes the result
//     sum       : output [WIDTH-1:0] result bits
//     cout      : output carry out of bit WIDTH-1
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sa_state_t        state_reg;
  sa_state_t        state_next;

  logic [WIDTH-1:0] a_sh_reg;
  logic [WIDTH-1:0] b_sh_reg;
  logic [WIDTH-1:0] sum_sh_reg;
  logic [WIDTH-1:0] sum_sh_next;
  logic [WIDTH-1:0] sum_reg;
  logic             cout_reg;
  logic             carry_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             fa_s;
  logic             fa_co;
  logic             accept;
  logic             last_bit;

  logic [WIDTH-1:0] b_load;
  logic             carry_init;

`ifdef SERIAL_ADDER_SUB_EN
  // Two's-complement subtract: a + ~b + 1.
  assign b_load     = sub ? ~b : b;
  assign carry_init = sub;
`else
  assign b_load     = b;
  assign carry_init = 1'b0;
`endif

  // ---------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  assign last_bit = (cnt_reg == LAST_CNT);

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        // Gated by rst_n so the block never advertises readiness in reset.
        in_ready = rst_n;
        if (in_valid) begin
          accept     = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------
  // Datapath: one full-adder cell, carry register, shift registers
  // ---------------------------------------------------------------
  full_adder_bit u_fa (
    .x   (a_sh_reg[0]),
    .y   (b_sh_reg[0]),
    .cin (carry_reg),
    .s   (fa_s),
    .co  (fa_co)
  );

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at [0].
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sum_shift
      if (gi == WIDTH - 1) begin : g_msb
        assign sum_sh_next[gi] = fa_s;
      end else begin : g_lower
        assign sum_sh_next[gi] = sum_sh_reg[gi + 1];
      end
    end
  endgenerate

  // The working shift register is separate from the visible sum so the
  // previous result stays on 'sum' until the next one is complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_reg   <= '0;
      b_sh_reg   <= '0;
      sum_sh_reg <= '0;
      sum_reg    <= '0;
      cout_reg   <= 1'b0;
      carry_reg  <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      if (accept) begin
        a_sh_reg  <= a;
        b_sh_reg  <= b_load;
        carry_reg <= carry_init;
        cnt_reg   <= '0;
      end else if (state_reg == ADD) begin
        a_sh_reg   <= a_sh_reg >> 1;
        b_sh_reg   <= b_sh_reg >> 1;
        carry_reg  <= fa_co;
        sum_sh_reg <= sum_sh_next;
        cnt_reg    <= cnt_reg + CNT_W'(1);
        if (last_bit) begin
          sum_reg  <= sum_sh_next;
          cout_reg <= fa_co;
        end
      end
    end
  end

  assign sum  = sum_reg;
  assign cout = cout_reg;

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
//   Self-checking bench for serial_adder (WIDTH=8). Expected results come
//   from plain integer arithmetic on the operands; the random test keeps a
//   queue of expected results in request order.
//   Build with SERIAL_ADDER_SUB_EN to include the subtract scenario.
module tb_serial_adder;

  localparam int W = 8;
  localparam int N_RANDOM = 1000;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int checks;
  int errors;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present a request (caller sits at a negedge); returns at the negedge
  // right after the handshake edge, i.e. in cycle 1 of the operation.
  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv);
    a        = av;
    b        = bv;
    in_valid = 1'b1;
    for (int i = 0; i < 100 && in_ready !== 1'b1; i++) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_timeout in_ready=%b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for out_valid; lat is the cycle index where it was seen.
  task automatic wait_out(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
`ifdef SERIAL_ADDER_SUB_EN
    sub       = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_state in_ready=%b out_valid=%b sum=%h cout=%b required 0 0 00 0",
               in_ready, out_valid, sum, cout);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    $display("reset done");
  endtask

  task automatic test_basic;
    int lat;
    out_ready = 1'b1;
    send(8'h35, 8'h4A);
    wait_out(lat);
    $display("basic a=35 b=4A latency=%0d sum=%h cout=%b", lat, sum, cout);
    checks++;
    if (lat != W + 1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency got=%0d valid=%b required %0d", lat, out_valid, W + 1);
    end
    checks++;
    if (sum !== 8'h7F || cout !== 1'b0) begin
      errors++;
      $display("FAIL basic_result got=%b_%h required 0_7F", cout, sum);
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_return out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    out_ready = 1'b1;
    send(8'h0F, 8'h01);
    repeat (2) @(negedge clk);   // now in the 3rd ADD cycle
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || sum !== '0 || cout !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset_abort out_valid=%b sum=%h cout=%b in_ready=%b required 0 00 0 0",
               out_valid, sum, cout, in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    send(8'h02, 8'h03);
    wait_out(lat);
    $display("midreset follow-up a=02 b=03 sum=%h cout=%b", sum, cout);
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h05 || cout !== 1'b0) begin
      errors++;
      $display("FAIL midreset_next got=%b valid=%b_%h required 1 0_05", out_valid, cout, sum);
    end
    @(negedge clk);
  endtask

  task automatic test_overflow;
    logic [W-1:0] ta [4];
    logic [W-1:0] tb [4];
    logic [W:0]   exp;
    int           lat;
    ta[0] = 8'hFF; tb[0] = 8'hFF;
    ta[1] = 8'h80; tb[1] = 8'h80;
    ta[2] = 8'h00; tb[2] = 8'h00;
    ta[3] = 8'hFF; tb[3] = 8'h01;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp = {1'b0, ta[i]} + {1'b0, tb[i]};
      send(ta[i], tb[i]);
      wait_out(lat);
      $display("overflow a=%h b=%h sum=%h cout=%b", ta[i], tb[i], sum, cout);
      checks++;
      if (out_valid !== 1'b1 || {cout, sum} !== exp) begin
        errors++;
        $display("FAIL overflow_%0d got=%b valid=%b_%h required %b_%h",
                 i, out_valid, cout, sum, exp[W], exp[W-1:0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    int stray_valid;
    out_ready = 1'b0;
    send(8'h5A, 8'hC3);  // 0x11D
    wait_out(lat);
    $display("backpressure a=5A b=C3 sum=%h cout=%b", sum, cout);
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h1D || cout !== 1'b1) begin
      errors++;
      $display("FAIL bp_result got=%b valid=%b_%h required 1 1_1D", out_valid, cout, sum);
    end
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a        = W'($urandom);
      b        = W'($urandom);
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 8'h1D || cout !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold_%0d out_valid=%b in_ready=%b sum=%h cout=%b required 1 0 1D 1",
                 i, out_valid, in_ready, sum, cout);
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 8'h1D) begin
      errors++;
      $display("FAIL bp_release out_valid=%b in_ready=%b sum=%h required 0 1 1D",
               out_valid, in_ready, sum);
    end
    // Ignored in_valid pulses must not have been queued.
    stray_valid = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) stray_valid++;
    end
    checks++;
    if (stray_valid != 0) begin
      errors++;
      $display("FAIL bp_no_extra stray_valid_cycles=%0d required 0", stray_valid);
    end
  endtask

`ifdef SERIAL_ADDER_SUB_EN
  task automatic test_sub;
    int lat;
    out_ready = 1'b1;
    sub = 1'b1;
    send(8'h10, 8'h03);
    wait_out(lat);
    $display("sub a=10 b=03 sum=%h cout=%b", sum, cout);
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'h0D || cout !== 1'b1) begin
      errors++;
      $display("FAIL sub_pos got=%b valid=%b_%h required 1 1_0D", out_valid, cout, sum);
    end
    @(negedge clk);
    send(8'h03, 8'h10);
    wait_out(lat);
    $display("sub a=03 b=10 sum=%h cout=%b", sum, cout);
    checks++;
    if (out_valid !== 1'b1 || sum !== 8'hF3 || cout !== 1'b0) begin
      errors++;
      $display("FAIL sub_neg got=%b valid=%b_%h required 1 0_F3", out_valid, cout, sum);
    end
    @(negedge clk);
    sub = 1'b0;
  endtask
`endif

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corner [4];
    corner[0] = 8'h00;
    corner[1] = 8'hFF;
    corner[2] = 8'h80;
    corner[3] = 8'h01;
    if ($urandom_range(0, 7) == 0) return corner[$urandom_range(0, 3)];
    return W'($urandom);
  endfunction

  task automatic test_random;
    logic [W:0] q [$];
    logic [W:0] exp;
    int         sent;
    int         got;
    bit         accepted;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sent      = 0;
    got       = 0;
    for (int cyc = 0; cyc < 40000 && got < N_RANDOM; cyc++) begin
      @(negedge clk);
      accepted = 1'b0;
      checks++;
      if (in_ready === 1'b1 && out_valid === 1'b1) begin
        errors++;
        $display("FAIL rand_ready_valid_overlap in_ready=1 out_valid=1 required not both");
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        q.push_back({1'b0, a} + {1'b0, b});
        sent++;
        accepted = 1'b1;
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_unexpected_result got=%b_%h required none", cout, sum);
        end else begin
          exp = q.pop_front();
          $display("rand #%0d sum=%h cout=%b expected=%b_%h", got, sum, cout, exp[W], exp[W-1:0]);
          if ({cout, sum} !== exp) begin
            errors++;
            $display("FAIL rand_result_%0d got=%b_%h required %b_%h",
                     got, cout, sum, exp[W], exp[W-1:0]);
          end
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (!in_valid || accepted) begin
        a        = pick_operand();
        b        = pick_operand();
        in_valid = (sent < N_RANDOM) && ($urandom_range(0, 3) != 0);
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid = 1'b0;
    checks++;
    if (got != N_RANDOM || q.size() != 0) begin
      errors++;
      $display("FAIL rand_count got=%0d pending=%0d required %0d 0", got, q.size(), N_RANDOM);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_reset_mid();
    test_overflow();
    test_backpressure();
`ifdef SERIAL_ADDER_SUB_EN
    test_sub();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
